// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    // Internal occupancy counters, zero-extended, for observation only.
    typedef struct packed {
        logic [7:0] count;
        logic [7:0] inflight;
        logic [7:0] drop_cnt;
    } fq_dbg_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory, E stage and decode.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side never withdraws req_valid because of
// req_ready, and req_addr is stable while req_valid waits. Responses have no
// ready: every rsp_valid cycle is one response, returned in request order.
// Decode takes the head entry on out_valid && out_ready.
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic            out_ready;
    fetch_pkg::fq_dbg_t dbg;

    modport master (
        output req_valid, req_addr, out_valid, out_instr, out_pc, out_pc_plus4, dbg,
        input  req_ready, rsp_valid, rsp_data, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_instr, out_pc, out_pc_plus4, dbg,
        output req_ready, rsp_valid, rsp_data, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Power-of-two circular buffer with push, pop and a clear that wins over both.
// No fall-through: a pushed word is readable from the following cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited request issue,
// in-order response capture and stale-response dropping after a redirect.
module fetch_queue #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    import fetch_pkg::*;

    localparam int CW  = $clog2(DEPTH+1);
    localparam int IW  = $clog2(MAX_OUT+1);
    localparam int CRW = CW + IW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic [IW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count;
    logic [CRW-1:0]  credit_used;
    logic            req_valid;
    logic            issue;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic            clear;
    fq_entry_t       wr_entry;
    fq_entry_t       rd_entry;

    // Stale in-flight words still hold a credit until they come back, so they
    // are counted; ones already marked for dropping will never occupy a slot.
    // A same-cycle pop is not credited, which keeps the queue from overflowing.
    assign credit_used = CRW'(count) + CRW'(inflight_q) - CRW'(drop_cnt_q);
    assign req_valid   = rst && !bus.redirect && (inflight_q < IW'(MAX_OUT))
                         && (credit_used < CRW'(DEPTH));
    assign issue       = req_valid && bus.req_ready;
    assign out_valid   = (count != '0);

    assign bus.req_valid    = req_valid;
    assign bus.req_addr     = fetch_pc_q;
    assign bus.out_valid    = out_valid;
    assign bus.out_instr    = rd_entry.instr;
    assign bus.out_pc       = rd_entry.pc;
    assign bus.out_pc_plus4 = rd_entry.pc + XLEN'(4);
    assign bus.dbg          = {8'(count), 8'(inflight_q), 8'(drop_cnt_q)};

    // PC counters, outstanding/drop bookkeeping and queue control; a redirect
    // overrides issue, push and pop in its own cycle.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        inflight_d     = inflight_q;
        drop_cnt_d     = drop_cnt_q;
        push           = 1'b0;
        pop            = 1'b0;
        clear          = 1'b0;
        wr_entry.pc    = resp_pc_q;
        wr_entry.instr = bus.rsp_data;
        if (bus.redirect) begin
            clear      = 1'b1;
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            inflight_d = inflight_q - IW'(bus.rsp_valid);
            drop_cnt_d = inflight_q - IW'(bus.rsp_valid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            inflight_d = inflight_q + IW'(issue) - IW'(bus.rsp_valid);
            pop        = out_valid && bus.out_ready;
            if (bus.rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - IW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fq_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count)
    );

    a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
        bus.rsp_valid |-> (inflight_q != '0));
    a_req_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
        bus.req_addr[1:0] == 2'b00);
    a_redirect_pc_aligned: assert property (@(posedge clk) disable iff (!rst)
        bus.redirect |-> (bus.redirect_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory responder, queue-based
// reference model compared every cycle, and literal spot checks per scenario.
module tb_fetch_queue;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk;
    logic rst;
    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC))
        dut (.clk(clk), .rst(rst), .bus(bus.master));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // ---------------- memory responder ----------------
    int          cyc = 0;
    int          mem_lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    initial begin
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst) begin
                pend_addr.delete();
                pend_due.delete();
                bus.rsp_valid = 1'b0;
            end else if (pend_addr.size() != 0 && cyc >= pend_due[0]) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                bus.rsp_valid = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [63:0] exp_q[$];
    logic [63:0] out_log[$];
    logic [31:0] req_log[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] m_resp_pc  = RESET_PC;
    int          m_inflight = 0;
    int          m_drop     = 0;
    logic        exp_rv;
    logic [31:0] head_pc;
    logic [31:0] head_p4;

    always @(negedge clk) begin
        exp_rv = rst && !bus.redirect && (m_inflight < MAX_OUT)
                 && (exp_q.size() + m_inflight - m_drop < DEPTH);
        if (started) begin
            chk("req_valid", bus.req_valid, exp_rv);
            chk("req_addr", bus.req_addr, m_fetch_pc);
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            chk("count", bus.dbg.count, exp_q.size());
            chk("inflight", bus.dbg.inflight, m_inflight);
            chk("drop_cnt", bus.dbg.drop_cnt, m_drop);
            if (exp_q.size() != 0) begin
                head_pc = exp_q[0][63:32];
                head_p4 = head_pc + 32'd4;
                chk("out_pc", bus.out_pc, head_pc);
                chk("out_instr", bus.out_instr, exp_q[0][31:0]);
                chk("out_pc_plus4", bus.out_pc_plus4, head_p4);
            end
        end
        if (rst && bus.req_valid && bus.req_ready) begin
            pend_addr.push_back(bus.req_addr);
            pend_due.push_back(cyc + mem_lat);
        end
        if (!rst) begin
            exp_q.delete();
            out_log.delete();
            req_log.delete();
            m_fetch_pc = RESET_PC;
            m_resp_pc  = RESET_PC;
            m_inflight = 0;
            m_drop     = 0;
        end else if (bus.redirect) begin
            exp_q.delete();
            m_fetch_pc = bus.redirect_pc;
            m_resp_pc  = bus.redirect_pc;
            m_inflight = m_inflight - int'(bus.rsp_valid);
            m_drop     = m_inflight;
        end else begin
            if (exp_rv && bus.req_ready) begin
                req_log.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_inflight++;
            end
            if (exp_q.size() != 0 && bus.out_ready) begin
                out_log.push_back(exp_q.pop_front());
            end
            if (bus.rsp_valid) begin
                m_inflight--;
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    exp_q.push_back({m_resp_pc, bus.rsp_data});
                    m_resp_pc = m_resp_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        tick(1);
        bus.redirect    = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    int          n0;
    int          k;
    logic [31:0] p;
    logic [31:0] a0;
    logic [7:0]  infl;
    logic        rv_at_redir;

    initial begin
        rst             = 1'b0;
        bus.req_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        tick(3);
        started = 1'b1;
        tick(1);

        // reset state
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_req_valid", bus.req_valid, 1'b0);
        chk("rst_count", bus.dbg.count, 8'd0);
        chk("rst_req_addr", bus.req_addr, RESET_PC);

        // 1-cycle memory, decode always ready
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick(12);
        chk("t1_req_n", req_log.size() >= 3, 1'b1);
        if (req_log.size() >= 3) begin
            chk("t1_req0", req_log[0], 32'h0);
            chk("t1_req1", req_log[1], 32'h4);
            chk("t1_req2", req_log[2], 32'h8);
        end
        chk("t1_out_n", out_log.size() >= 2, 1'b1);
        if (out_log.size() >= 2) begin
            chk("t1_out0", out_log[0], {32'h0, 32'hFFFF0000});
            chk("t1_out1", out_log[1], {32'h4, 32'hFFFB0004});
        end
        n0 = out_log.size();
        tick(10);
        chk("t1_no_gaps", out_log.size() - n0, 10);

        // decode stalled: queue saturates, issue stops
        bus.out_ready = 1'b0;
        tick(10);
        chk("t2_count_full", bus.dbg.count, 8'd4);
        chk("t2_req_blocked", bus.req_valid, 1'b0);
        chk("t2_inflight", bus.dbg.inflight, 8'd0);
        n0 = out_log.size();
        p  = out_log[n0-1][63:32];
        bus.out_ready = 1'b1;
        tick(6);
        chk("t2_drain_n", out_log.size() >= n0 + 4, 1'b1);
        if (out_log.size() >= n0 + 4) begin
            chk("t2_drain0", out_log[n0][63:32], p + 32'd4);
            chk("t2_drain3", out_log[n0+3][63:32], p + 32'd16);
        end

        // redirect with two requests outstanding
        mem_lat = 3;
        tick(8);
        for (k = 0; k < 20 && bus.dbg.inflight != 8'd2; k++) tick(1);
        chk("t3_two_out", bus.dbg.inflight, 8'd2);
        rv_at_redir = bus.rsp_valid;
        n0 = out_log.size();
        do_redirect(32'h100);
        chk("t3_out_valid", bus.out_valid, 1'b0);
        chk("t3_drop", bus.dbg.drop_cnt, 8'd2 - 8'(rv_at_redir));
        for (k = 0; k < 20 && !bus.out_valid; k++) tick(1);
        chk("t3_pc", bus.out_pc, 32'h100);
        chk("t3_instr", bus.out_instr, 32'hFEFF0100);
        tick(2);
        chk("t3_log_n", out_log.size() > n0, 1'b1);
        if (out_log.size() > n0) chk("t3_first_after", out_log[n0], {32'h100, 32'hFEFF0100});

        // redirect with a nearly full queue and a response in the same cycle
        mem_lat = 2;
        bus.out_ready = 1'b0;
        for (k = 0; k < 30 && !(bus.dbg.count == 8'd3 && bus.rsp_valid && bus.dbg.drop_cnt == 8'd0); k++)
            tick(1);
        chk("t4_setup", bus.dbg.count == 8'd3 && bus.rsp_valid, 1'b1);
        infl = bus.dbg.inflight;
        do_redirect(32'h200);
        chk("t4_out_valid", bus.out_valid, 1'b0);
        chk("t4_count", bus.dbg.count, 8'd0);
        chk("t4_drop", bus.dbg.drop_cnt, infl - 8'd1);
        bus.out_ready = 1'b1;
        for (k = 0; k < 20 && !bus.out_valid; k++) tick(1);
        chk("t4_pc", bus.out_pc, 32'h200);
        chk("t4_instr", bus.out_instr, 32'hFDFF0200);

        // memory back-pressure: address holds, queue drains
        mem_lat = 1;
        tick(6);
        bus.req_ready = 1'b0;
        a0 = m_fetch_pc;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t5_addr_hold", bus.req_addr, a0);
        end
        tick(1);
        chk("t5_drained", bus.out_valid, 1'b0);
        bus.req_ready = 1'b1;

        // reset mid-stream
        tick(8);
        rst = 1'b0;
        tick(1);
        chk("t6_req_addr", bus.req_addr, RESET_PC);
        chk("t6_out_valid", bus.out_valid, 1'b0);
        chk("t6_count", bus.dbg.count, 8'd0);
        chk("t6_inflight", bus.dbg.inflight, 8'd0);
        chk("t6_drop", bus.dbg.drop_cnt, 8'd0);
        rst = 1'b1;
        tick(6);
        chk("t6_log_n", out_log.size() >= 1, 1'b1);
        if (out_log.size() >= 1) chk("t6_first", out_log[0], {32'h0, 32'hFFFF0000});

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
